riscv_mul_arb: RTL and testbench

Round-robin arbiter that shares one fixed-latency pipelined multiplier between NREQ requesters, e.g. the integer EX stage and a second execution client. It accepts valid/ready requests, issues at most one operation per cycle, tracks ownership of in-flight operations through a tag pipeline, and returns each result through a per-requester one-entry response buffer with valid/ready backpressure.

---
 rtl/riscv_mul_arb.sv | 134 +++++++++++++
 tb/tb_riscv_mul_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mul_arb.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier between NREQ requesters.
// Define MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest eligible index wins, no pointer).
module riscv_mul_arb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*3-1:0]    req_func_i,
  input  logic [NREQ*XLEN-1:0] req_opA_i,
  input  logic [NREQ*XLEN-1:0] req_opB_i,
  output logic                 mul_valid_o,
  output logic [2:0]           mul_func_o,
  output logic [XLEN-1:0]      mul_opA_o,
  output logic [XLEN-1:0]      mul_opB_o,
  input  logic [XLEN-1:0]      mul_r_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [NREQ*XLEN-1:0] rsp_r_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    outstanding_q;
  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    grant;
  logic [IW-1:0]      gidx;
  logic               accept;
  logic [LATENCY-1:0] tag_v_q;
  logic [IW-1:0]      tag_o_q [LATENCY];
  logic [NREQ-1:0]    rsp_valid_q;
  logic [XLEN-1:0]    rsp_r_q [NREQ];

  assign eligible = req_valid_i & ~outstanding_q;

`ifdef MUL_ARB_FIXED_PRIO_EN
  // Scan downwards so the lowest eligible index is the last (winning) assignment.
  always_comb begin
    logic [IW-1:0] ki;
    grant = '0;
    gidx  = '0;
    ki    = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      ki = IW'(k - 1);
      if (eligible[ki]) begin
        grant     = '0;
        grant[ki] = 1'b1;
        gidx      = ki;
      end
    end
  end
`else
  logic [IW-1:0] ptr_q;

  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(ptr_q) + k) % NREQ);
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (accept) begin
      ptr_q <= gidx;
    end
  end
`endif

  assign req_ready_o = grant & ~outstanding_q & {NREQ{~flush_i & ~rst_i}};
  assign accept      = |(req_valid_i & req_ready_o);

  always_comb begin
    mul_valid_o = accept;
    mul_func_o  = '0;
    mul_opA_o   = '0;
    mul_opB_o   = '0;
    if (accept) begin
      mul_func_o = req_func_i[32'(gidx)*3 +: 3];
      mul_opA_o  = req_opA_i[32'(gidx)*XLEN +: XLEN];
      mul_opB_o  = req_opB_i[32'(gidx)*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      tag_v_q       <= '0;
      rsp_valid_q   <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) tag_o_q[s] <= '0;
      for (int unsigned i = 0; i < NREQ; i++) rsp_r_q[i] <= '0;
    end else if (flush_i) begin
      outstanding_q <= '0;
      tag_v_q       <= '0;
      rsp_valid_q   <= '0;
    end else begin
      outstanding_q <= (outstanding_q & ~(rsp_valid_q & rsp_ready_i)) | (req_valid_i & req_ready_o);
      tag_v_q[0]    <= accept;
      tag_o_q[0]    <= gidx;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        tag_v_q[s] <= tag_v_q[s-1];
        tag_o_q[s] <= tag_o_q[s-1];
      end
      // Capture overrides the drain term; the owner's buffer is empty by the one-outstanding rule.
      rsp_valid_q <= rsp_valid_q & ~rsp_ready_i;
      if (tag_v_q[LATENCY-1]) begin
        rsp_valid_q[tag_o_q[LATENCY-1]] <= 1'b1;
        rsp_r_q[tag_o_q[LATENCY-1]]     <= mul_r_i;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_rsp
    assign rsp_r_o[g*XLEN +: XLEN] = rsp_r_q[g];
  end

endmodule

// File: tb/tb_riscv_mul_arb.sv
// Self-checking bench for riscv_mul_arb: table vectors, scoreboard, and multi-cycle corner sequences.
module tb_riscv_mul_arb;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned LATENCY = 2;

  logic                 clk = 1'b0;
  logic                 rst, flush;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*3-1:0]    req_func;
  logic [NREQ*XLEN-1:0] req_opA, req_opB, rsp_r;
  logic                 mul_valid;
  logic [2:0]           mul_func;
  logic [XLEN-1:0]      mul_opA, mul_opB, mul_r;

  riscv_mul_arb #(.XLEN(XLEN), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_func_i(req_func),
    .req_opA_i(req_opA), .req_opB_i(req_opB),
    .mul_valid_o(mul_valid), .mul_func_o(mul_func), .mul_opA_o(mul_opA), .mul_opB_o(mul_opB),
    .mul_r_i(mul_r),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_r_o(rsp_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mulf(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, ss, su, uu;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'b0, a};       ub = {32'b0, b};
    ss = sa * sb; su = sa * ub; uu = ua * ub;
    case (f)
      3'd0:    return uu[31:0];
      3'd1:    return ss[63:32];
      3'd2:    return su[63:32];
      3'd3:    return uu[63:32];
      3'd4:    return uu[31:0];
      default: return a ^ b;
    endcase
  endfunction

  // External multiplier model with a garbage value whenever nothing is in flight.
  logic [XLEN-1:0] mpipe [LATENCY];
  always @(posedge clk) begin
    mpipe[0] <= mul_valid ? mulf(mul_func, mul_opA, mul_opB) : 32'hDEAD_BEEF;
    for (int s = 1; s < LATENCY; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_r = mpipe[LATENCY-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int unsigned idx; logic [31:0] val; } sb_t;
  typedef struct { int unsigned idx; int cyc; } ev_t;
  sb_t sb_q[$];
  ev_t grant_log[$];
  ev_t rsp_log[$];

  logic [NREQ-1:0] acc_m;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      acc_m = req_valid & req_ready;
      check("one_grant", 64'($countones(acc_m) <= 1), 64'd1);
      if (acc_m == '0) begin
        check("mul_idle_valid", 64'(mul_valid), 64'd0);
        check("mul_idle_ops", {29'b0, mul_func, mul_opA | mul_opB}, 64'd0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc_m[i]) begin
          check("issue_func", 64'(mul_func), 64'(req_func[i*3 +: 3]));
          check("issue_opA", 64'(mul_opA), 64'(req_opA[i*XLEN +: XLEN]));
          check("issue_opB", 64'(mul_opB), 64'(req_opB[i*XLEN +: XLEN]));
          sb_q.push_back('{idx: i, val: mulf(req_func[i*3 +: 3], req_opA[i*XLEN +: XLEN], req_opB[i*XLEN +: XLEN])});
          grant_log.push_back('{idx: i, cyc: cyc});
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          int k;
          k = -1;
          foreach (sb_q[j]) if (k < 0 && sb_q[j].idx == i) k = j;
          rsp_log.push_back('{idx: i, cyc: cyc});
          if (k < 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: requester %0d data %0h with nothing expected", i, rsp_r[i*XLEN +: XLEN]);
          end else begin
            check("rsp_data", 64'(rsp_r[i*XLEN +: XLEN]), 64'(sb_q[k].val));
            sb_q.delete(k);
          end
        end
      end
      if (flush) sb_q.delete();
    end
  end

  task automatic set_req(input int r, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    req_func[r*3 +: 3]     = f;
    req_opA[r*XLEN +: XLEN] = a;
    req_opB[r*XLEN +: XLEN] = b;
    req_valid[r]            = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_accept(input int r, output int t);
    t = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_valid[r] && req_ready[r]) begin t = cyc; break; end
    end
    if (t < 0) begin checks++; errors++; $display("FAIL accept_timeout: requester %0d never accepted", r); end
  endtask

  task automatic wait_rsp(input int r, output int t);
    t = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rsp_valid[r]) begin t = cyc; break; end
    end
    if (t < 0) begin checks++; errors++; $display("FAIL rsp_timeout: requester %0d never responded", r); end
  endtask

  typedef struct { int unsigned r; logic [2:0] f; logic [31:0] a, b, exp; } vec_t;
  vec_t tbl [8];

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, n1;
    int prev;
    tbl[0] = '{0, 3'd0, 32'd3,         32'd5,         32'd15};
    tbl[1] = '{1, 3'd0, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE};
    tbl[2] = '{2, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[3] = '{3, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[4] = '{0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[5] = '{1, 3'd1, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    tbl[6] = '{2, 3'd4, 32'h0001_0000, 32'h0001_0000, 32'd0};
    tbl[7] = '{3, 3'd5, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF};

    rst = 1'b1; flush = 1'b0; rsp_ready = '1;
    req_valid = '1; req_func = '1; req_opA = '1; req_opB = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mul_valid", 64'(mul_valid), 64'd0);
    check("rst_mul_ops", {29'b0, mul_func, mul_opA | mul_opB}, 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_r_zero", 64'(rsp_r == '0), 64'd1);
    req_valid = '0; req_func = '0; req_opA = '0; req_opB = '0;
    @(posedge clk); #1 rst = 1'b0;

    // Single isolated requests: latency and result per table row.
    foreach (tbl[v]) begin
      set_req(tbl[v].r, tbl[v].f, tbl[v].a, tbl[v].b);
      wait_accept(tbl[v].r, t);
      @(posedge clk); #1 req_valid[tbl[v].r] = 1'b0;
      wait_rsp(tbl[v].r, t2);
      check("tbl_latency", 64'(t2 - t), 64'(LATENCY + 1));
      check("tbl_result", 64'(rsp_r[tbl[v].r*XLEN +: XLEN]), 64'(tbl[v].exp));
      repeat (2) @(posedge clk); #1;
    end

    // Contention between requesters 0 and 1 from reset.
    do_reset();
    grant_log.delete(); rsp_log.delete();
    set_req(0, 3'd0, 32'd11, 32'd13);
    set_req(1, 3'd0, 32'd17, 32'd19);
    repeat (12) @(posedge clk);
    #1 req_valid = '0;
    repeat (8) @(posedge clk); #1;
    check("cont_grants", 64'(grant_log.size() >= 4), 64'd1);
    check("cont_rsps", 64'(rsp_log.size() >= 2), 64'd1);
    if (grant_log.size() >= 4 && rsp_log.size() >= 2) begin
      check("cont_g0", 64'(grant_log[0].idx), 64'd0);
      check("cont_g1", 64'(grant_log[1].idx), 64'd1);
      check("cont_g1_t", 64'(grant_log[1].cyc - grant_log[0].cyc), 64'd1);
      check("cont_g2", 64'(grant_log[2].idx), 64'd0);
      check("cont_g2_t", 64'(grant_log[2].cyc - grant_log[0].cyc), 64'd4);
      check("cont_g3_t", 64'(grant_log[3].cyc - grant_log[0].cyc), 64'd5);
      check("cont_r0", 64'(rsp_log[0].idx), 64'd0);
      check("cont_r0_t", 64'(rsp_log[0].cyc - grant_log[0].cyc), 64'd3);
      check("cont_r1", 64'(rsp_log[1].idx), 64'd1);
      check("cont_r1_t", 64'(rsp_log[1].cyc - grant_log[0].cyc), 64'd4);
    end

    // Backpressure on requester 0 while requester 1 keeps issuing.
    do_reset();
    rsp_ready = 4'b1110;
    set_req(0, 3'd0, 32'd7, 32'd6);
    wait_accept(0, t);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_rsp(0, t2);
    @(posedge clk); #1;
    grant_log.delete();
    set_req(0, 3'd0, 32'd1, 32'd1);
    set_req(1, 3'd0, 32'd9, 32'd9);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid[0]), 64'd1);
      check("bp_rsp_r", 64'(rsp_r[0 +: XLEN]), 64'd42);
      check("bp_req_ready", 64'(req_ready[0]), 64'd0);
    end
    @(posedge clk); #1 req_valid[1] = 1'b0; rsp_ready[0] = 1'b1;
    n1 = 0; prev = -1;
    foreach (grant_log[k]) begin
      check("bp_only_req1", 64'(grant_log[k].idx), 64'd1);
      if (prev >= 0) check("bp_period", 64'(grant_log[k].cyc - prev), 64'(LATENCY + 2));
      prev = grant_log[k].cyc;
      n1++;
    end
    check("bp_req1_count", 64'(n1), 64'd3);
    wait_accept(0, t);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Flush right after accepting requester 1.
    rsp_ready = '1;
    set_req(1, 3'd0, 32'd100, 32'd3);
    wait_accept(1, t);
    @(posedge clk); #1 flush = 1'b1; set_req(1, 3'd0, 32'd7, 32'd7);
    @(negedge clk);
    check("fl_blocked", 64'(req_ready[1]), 64'd0);
    check("fl_no_issue", 64'(mul_valid), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("fl_reaccept", 64'(req_ready[1]), 64'd1);
    check("fl_reaccept_t", 64'(cyc - t), 64'd2);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("fl_no_stale", 64'(rsp_valid[1]), 64'd0);
    end
    @(negedge clk);
    check("fl_new_rsp", 64'(rsp_valid[1]), 64'd1);
    check("fl_new_data", 64'(rsp_r[XLEN +: XLEN]), 64'd49);
    repeat (3) @(posedge clk); #1;

    // Reset in the cycle after an accept.
    set_req(0, 3'd3, 32'hFFFF_FFFF, 32'd2);
    wait_accept(0, t);
    @(posedge clk); #1 rst = 1'b1; set_req(0, 3'd0, 32'd6, 32'd7);
    @(negedge clk);
    check("rs_blocked", 64'(req_ready[0]), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rs_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rs_rsp_r_zero", 64'(rsp_r == '0), 64'd1);
    check("rs_accept", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rs_no_stale", 64'(rsp_valid[0]), 64'd0);
    end
    @(negedge clk);
    check("rs_new_rsp", 64'(rsp_valid[0]), 64'd1);
    check("rs_new_data", 64'(rsp_r[0 +: XLEN]), 64'd42);
    repeat (3) @(posedge clk); #1;

    // Round-robin fairness with all four requesters valid.
    do_reset();
    rsp_ready = '1;
    grant_log.delete();
    for (int r = 0; r < NREQ; r++) set_req(r, 3'd0, 32'(r + 2), 32'(r + 3));
    repeat (12) @(posedge clk);
    #1 req_valid = '0;
    repeat (8) @(posedge clk); #1;
    check("rr_count", 64'(grant_log.size() >= 8), 64'd1);
    if (grant_log.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        check("rr_order", 64'(grant_log[k].idx), 64'(k % NREQ));
        if (k > 0) check("rr_back_to_back", 64'(grant_log[k].cyc - grant_log[k-1].cyc), 64'd1);
      end
    end

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
